// File: rtl/systolic_pkg.sv
// systolic_pkg: FSM state type and sizing helpers shared by systolic_nbyn.
// Optional feature macro: SYSTOLIC_SAT_EN (saturating C elements).
package systolic_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Up to 2^KW-1 products of 2*DW bits each: clog2(2^KW) == KW guard bits.
    function automatic int acc_width(input int dw, input int kw);
        return 2 * dw + kw;
    endfunction

    // Cycles the last beat needs to reach the far corner PE.
    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one processing element; registers a/b/valid onward
// and accumulates a*b into its local accumulator when tagged valid.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          v_i,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] b_o,
    output logic          v_o,
    output logic [AW-1:0] acc_o
);

    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic            v_q;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_d;
    logic [2*DW-1:0] prod;

    assign prod = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};

    // Clear wins over accumulate; bubbles leave the accumulator alone
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (v_i) begin
            acc_d = acc_q + AW'(prod);
        end
    end

    // Pass operands right/down and update the accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            v_q   <= 1'b0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            v_q   <= v_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign v_o   = v_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_nbyn.sv
// systolic_nbyn: N x N output-stationary systolic matrix multiplier.
// Define SYSTOLIC_SAT_EN to saturate each C element instead of wrapping.
module systolic_nbyn
    import systolic_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int OW = 16,
    parameter int KW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KW-1:0]     k_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   a_col,
    input  logic [N*DW-1:0]   b_row,
    output logic              busy,
    output logic              done,
    output logic [N*N*OW-1:0] c_out
);

    localparam int AW  = acc_width(DW, KW);
    localparam int DL  = drain_len(N);
    localparam int DCW = $clog2(DL + 1);

    state_e         state_q;
    state_e         state_d;
    logic [KW-1:0]  klen_q;
    logic [KW-1:0]  klen_d;
    logic [KW-1:0]  beat_q;
    logic [KW-1:0]  beat_d;
    logic [DCW-1:0] dcnt_q;
    logic [DCW-1:0] dcnt_d;
    logic           accept;
    logic           clr;

    assign accept = in_valid && in_ready;

    // State, latched K, beat counter and drain counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            klen_q  <= '0;
            beat_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            beat_q  <= beat_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Next state: K=0 skips straight to DONE
    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        beat_d  = beat_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    klen_d  = k_len;
                    beat_d  = '0;
                    dcnt_d  = '0;
                    state_d = (k_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (beat_q == klen_q - KW'(1)) begin
                        state_d = S_DRAIN;
                        dcnt_d  = '0;
                    end else begin
                        beat_d = beat_q + KW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DCW'(DL - 1)) begin
                    state_d = S_DONE;
                end else begin
                    dcnt_d = dcnt_q + DCW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake/status outputs and accumulator clear on accepted start
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        clr      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                clr  = start;
            end
            S_LOAD: begin
                in_ready = 1'b1;
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Operand grids: a and valid flow right, b flows down
    logic [DW-1:0] a_h [N][N+1];
    logic          v_h [N][N+1];
    logic [DW-1:0] b_v [N+1][N];
    logic [AW-1:0] acc [N][N];

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_h[0][0] = a_col[0 +: DW];
            assign v_h[0][0] = accept;
            assign b_v[0][0] = b_row[0 +: DW];
        end else begin : g_delay
            logic [DW-1:0] a_sh_q [i];
            logic [DW-1:0] b_sh_q [i];
            logic [i-1:0]  v_sh_q;

            // i-stage skew: row i of A with its tag, column i of B
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) begin
                        a_sh_q[s] <= '0;
                        b_sh_q[s] <= '0;
                    end
                    v_sh_q <= '0;
                end else begin
                    a_sh_q[0] <= a_col[i*DW +: DW];
                    b_sh_q[0] <= b_row[i*DW +: DW];
                    v_sh_q[0] <= accept;
                    for (int s = 1; s < i; s++) begin
                        a_sh_q[s] <= a_sh_q[s-1];
                        b_sh_q[s] <= b_sh_q[s-1];
                        v_sh_q[s] <= v_sh_q[s-1];
                    end
                end
            end

            assign a_h[i][0] = a_sh_q[i-1];
            assign v_h[i][0] = v_sh_q[i-1];
            assign b_v[0][i] = b_sh_q[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(
                .DW(DW),
                .AW(AW)
            ) u_pe (
                .clk  (clk),
                .rst  (rst),
                .clr_i(clr),
                .a_i  (a_h[i][j]),
                .b_i  (b_v[i][j]),
                .v_i  (v_h[i][j]),
                .a_o  (a_h[i][j+1]),
                .b_o  (b_v[i+1][j]),
                .v_o  (v_h[i][j+1]),
                .acc_o(acc[i][j])
            );

            if (AW > OW) begin : g_narrow
                logic [AW-OW-1:0] hi;
                assign hi = acc[i][j][AW-1:OW];
`ifdef SYSTOLIC_SAT_EN
                assign c_out[(i*N+j)*OW +: OW] =
                    (|hi) ? {OW{1'b1}} : acc[i][j][OW-1:0];
`else
                logic unused_hi;
                assign unused_hi = |hi;
                assign c_out[(i*N+j)*OW +: OW] = acc[i][j][OW-1:0];
`endif
            end else begin : g_wide
                assign c_out[(i*N+j)*OW +: OW] = OW'(acc[i][j]);
            end
        end
    end

    // Outputs of the last column/row leave the array unused
    logic [N*(2*DW+1)-1:0] unused_edge;
    for (genvar k = 0; k < N; k++) begin : g_edge
        assign unused_edge[k*(2*DW+1) +: 2*DW+1] =
            {a_h[k][N], v_h[k][N], b_v[N][k]};
    end

endmodule

// File: tb/tb_systolic_nbyn.sv
// tb_systolic_nbyn: directed checks of systolic_nbyn at N=3, DW=8, OW=16.
// Expected overflow value follows SYSTOLIC_SAT_EN.
module tb_systolic_nbyn;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int OW = 16;
    localparam int KW = 8;
    localparam int CW = N * N * OW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*DW-1:0] a_col = '0;
    logic [N*DW-1:0] b_row = '0;
    logic            busy;
    logic            done;
    logic [CW-1:0]   c_out;

    int checks = 0;
    int failures = 0;

    logic [CW-1:0] exp_id;
    logic [CW-1:0] exp_ovf;
    logic [OW-1:0] ovf_elem;
    logic [CW-1:0] held;
    int            lat;
    bit            seen;

    always #5 clk = ~clk;

    systolic_nbyn #(
        .N (N),
        .DW(DW),
        .OW(OW),
        .KW(KW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .k_len   (k_len),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_col   (a_col),
        .b_row   (b_row),
        .busy    (busy),
        .done    (done),
        .c_out   (c_out)
    );

    task automatic check(input string tag, input logic [CW-1:0] obs,
                         input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_run(input int k);
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // ovf: all-255 operands; gap: bubble cycles between beats;
    // poke: pulse start alongside the second beat
    task automatic send_beats(input int k, input bit ovf, input int gap,
                              input bit poke);
        for (int b = 0; b < k; b++) begin
            in_valid = 1'b1;
            if (ovf) begin
                a_col = '1;
                b_row = '1;
            end else begin
                a_col = 24'(1) << (8 * b);
                b_row = {8'(3*b+3), 8'(3*b+2), 8'(3*b+1)};
            end
            if (poke && b == 1) start = 1'b1;
            @(posedge clk); #1;
            start    = 1'b0;
            in_valid = 1'b0;
            a_col    = 24'hA5A5A5;
            b_row    = 24'h5A5A5A;
            if (b < k - 1) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                exp_id[(i*N+j)*OW +: OW] = OW'(3 * i + j + 1);
`ifdef SYSTOLIC_SAT_EN
        ovf_elem = 16'hFFFF;
`else
        ovf_elem = 16'hF804;
`endif
        exp_ovf = {(N*N){ovf_elem}};

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", CW'(in_ready), '0);
        check("rst_busy", CW'(busy), '0);
        check("rst_done", CW'(done), '0);
        check("rst_c_out", c_out, '0);
        @(posedge clk); #1;
        rst = 1'b1;

        // identity, no bubbles
        begin_run(3);
        check("load_in_ready", CW'(in_ready), CW'(1));
        check("load_busy", CW'(busy), CW'(1));
        send_beats(3, 1'b0, 0, 1'b0);
        wait_done(lat);
        check("id_latency", CW'(lat), CW'(6));
        check("id_c_out", c_out, exp_id);
        @(posedge clk); #1;
        check("id_done_pulse", CW'(done), '0);
        check("id_idle_busy", CW'(busy), '0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("id_c_hold", c_out, exp_id);

        // identity with two bubble cycles between beats
        begin_run(3);
        send_beats(3, 1'b0, 2, 1'b0);
        wait_done(lat);
        check("bub_latency", CW'(lat), CW'(6));
        check("bub_c_out", c_out, exp_id);

        // all-255 operands, K=4
        begin_run(4);
        send_beats(4, 1'b1, 0, 1'b0);
        wait_done(lat);
        check("ovf_latency", CW'(lat), CW'(6));
        check("ovf_c_out", c_out, exp_ovf);

        // K=0 goes straight to DONE with cleared accumulators
        @(posedge clk); #1;
        start = 1'b1;
        k_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("k0_done", CW'(done), CW'(1));
        check("k0_in_ready", CW'(in_ready), '0);
        check("k0_c_out", c_out, '0);
        @(posedge clk); #1;
        check("k0_done_pulse", CW'(done), '0);
        check("k0_busy", CW'(busy), '0);

        // reset in the middle of DRAIN
        begin_run(3);
        send_beats(3, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst_c_out", c_out, '0);
        check("mid_rst_busy", CW'(busy), '0);
        check("mid_rst_done", CW'(done), '0);
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("mid_rst_no_done", CW'(seen), '0);
        begin_run(3);
        send_beats(3, 1'b0, 0, 1'b0);
        wait_done(lat);
        check("post_rst_latency", CW'(lat), CW'(6));
        check("post_rst_c_out", c_out, exp_id);

        // start pulsed during LOAD and during DONE
        begin_run(3);
        send_beats(3, 1'b0, 1, 1'b1);
        wait_done(lat);
        check("poke_latency", CW'(lat), CW'(6));
        check("poke_c_out", c_out, exp_id);
        held = c_out;
        start = 1'b1;
        k_len = KW'(0);
        @(posedge clk); #1;
        start = 1'b0;
        check("poke_done_ignored", CW'(busy), '0);
        check("poke_c_hold", c_out, held);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
